// File: rtl/memaccess_seq.sv
// Upstream sequencer for the LC-3 memaccess stage: turns one accepted memory-class
// instruction into the mem_state / M_Control access sequence, with stall and done.
module memaccess_seq #(
   parameter int ACCESS_CYCLES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] opcode,
   output logic [1:0] mem_state,
   output logic       M_Control,
   output logic       stall,
   output logic       done,
   output logic       err
);

   generate
      if ((ACCESS_CYCLES < 1) || (ACCESS_CYCLES > 15)) begin : g_bad_access_cycles
         $error("memaccess_seq: ACCESS_CYCLES must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] RELOAD  = 4'(ACCESS_CYCLES - 1);
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;

   // Encodings equal the mem_state codes, so mem_state is the state register itself.
   typedef enum logic [1:0] {
      S_READ     = 2'd0,
      S_IND_READ = 2'd1,
      S_WRITE    = 2'd2,
      S_IDLE     = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ind_q, ind_d;
   logic       store_q, store_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ind_q   <= 1'b0;
         store_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ind_q   <= ind_d;
         store_q <= store_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ind_d   = ind_q;
      store_d = store_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d = RELOAD;
               ind_d = 1'b0;
               case (opcode)
                  OP_LD, OP_LDR: begin
                     state_d = S_READ;
                     store_d = 1'b0;
                  end
                  OP_ST, OP_STR: begin
                     state_d = S_WRITE;
                     store_d = 1'b1;
                  end
                  OP_LDI: begin
                     state_d = S_IND_READ;
                     store_d = 1'b0;
                  end
                  OP_STI: begin
                     state_d = S_IND_READ;
                     store_d = 1'b1;
                  end
                  default: begin
                     cnt_d = cnt_q;
                     err_d = 1'b1;
                  end
               endcase
            end
         end
         S_IND_READ: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // Second access addresses memory with the pointer just read.
               state_d = store_q ? S_WRITE : S_READ;
               cnt_d   = RELOAD;
               ind_d   = 1'b1;
            end
         end
         default: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               ind_d   = 1'b0;
            end
         end
      endcase
   end

   assign mem_state = state_q;
   assign M_Control = ind_q && ((state_q == S_READ) || (state_q == S_WRITE));
   assign stall     = (state_q != S_IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_memaccess_seq.sv
// Directed bench for memaccess_seq: three instances (ACCESS_CYCLES = 1, 2, 3) driven
// cycle by cycle, outputs compared against hand-computed vectors.
module tb_memaccess_seq;

   logic       clock;
   logic       reset1, reset2, reset3;
   logic       start1, start2, start3;
   logic [3:0] opcode1, opcode2, opcode3;
   logic [1:0] ms1, ms2, ms3;
   logic       mc1, mc2, mc3;
   logic       st1, st2, st3;
   logic       dn1, dn2, dn3;
   logic       er1, er2, er3;

   int n_checks = 0;
   int n_pass   = 0;

   // Expected output vector: {mem_state, M_Control, stall, done, err}
   logic [5:0] exp_q[$];

   memaccess_seq #(.ACCESS_CYCLES(1)) u_ac1 (
      .clock(clock), .reset(reset1), .start(start1), .opcode(opcode1),
      .mem_state(ms1), .M_Control(mc1), .stall(st1), .done(dn1), .err(er1));
   memaccess_seq #(.ACCESS_CYCLES(2)) u_ac2 (
      .clock(clock), .reset(reset2), .start(start2), .opcode(opcode2),
      .mem_state(ms2), .M_Control(mc2), .stall(st2), .done(dn2), .err(er2));
   memaccess_seq #(.ACCESS_CYCLES(3)) u_ac3 (
      .clock(clock), .reset(reset3), .start(start3), .opcode(opcode3),
      .mem_state(ms3), .M_Control(mc3), .stall(st3), .done(dn3), .err(er3));

   // Clock and reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [5:0] ev(input logic [1:0] ms, input logic mc,
                                     input logic st, input logic dn, input logic er);
      return {ms, mc, st, dn, er};
   endfunction

   function automatic logic [5:0] obs(input int sel);
      case (sel)
         1:       return {ms1, mc1, st1, dn1, er1};
         2:       return {ms2, mc2, st2, dn2, er2};
         default: return {ms3, mc3, st3, dn3, er3};
      endcase
   endfunction

   task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
      n_checks++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got {ms,mc,stall,done,err}=%b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                  tag, got[5:4], got[3], got[2], got[1], got[0],
                  want[5:4], want[3], want[2], want[1], want[0]);
      end
   endtask

   // Driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_start(input int sel, input logic [3:0] op);
      case (sel)
         1:       begin start1 = 1'b1; opcode1 = op; end
         2:       begin start2 = 1'b1; opcode2 = op; end
         default: begin start3 = 1'b1; opcode3 = op; end
      endcase
   endtask

   task automatic clear_starts();
      start1 = 1'b0;
      start2 = 1'b0;
      start3 = 1'b0;
   endtask

   // Scoreboard: compare one queued vector per cycle, advancing a cycle after each.
   task automatic drain(input int sel, input string tag);
      logic [5:0] v;
      int cyc = 1;
      while (exp_q.size() > 0) begin
         v = exp_q.pop_front();
         check($sformatf("%s@%0d", tag, cyc), obs(sel), v);
         cyc++;
         tick();
      end
   endtask

   localparam logic [5:0] IDLE_V = 6'b11_0_0_0_0;

   initial begin
      reset1 = 1'b1; reset2 = 1'b1; reset3 = 1'b1;
      clear_starts();
      opcode1 = 4'd0; opcode2 = 4'd0; opcode3 = 4'd0;
      tick();
      tick();
      reset1 = 1'b0; reset2 = 1'b0; reset3 = 1'b0;

      // Reset state held for 5 idle cycles
      for (int i = 0; i < 5; i++) exp_q.push_back(IDLE_V);
      drain(1, "reset_idle_ac1");
      check("reset_idle_ac2", obs(2), IDLE_V);
      check("reset_idle_ac3", obs(3), IDLE_V);

      // LD, ACCESS_CYCLES=1
      drive_start(1, 4'b0010);
      tick();
      clear_starts();
      exp_q.push_back(ev(2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(ev(2'd3, 1'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(IDLE_V);
      drain(1, "ld_ac1");

      // STI, ACCESS_CYCLES=2
      drive_start(2, 4'b1011);
      tick();
      clear_starts();
      repeat (2) exp_q.push_back(ev(2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
      repeat (2) exp_q.push_back(ev(2'd2, 1'b1, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(ev(2'd3, 1'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(IDLE_V);
      drain(2, "sti_ac2");

      // Non-memory opcode (ADD)
      drive_start(2, 4'b0001);
      tick();
      clear_starts();
      exp_q.push_back(ev(2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(IDLE_V);
      drain(2, "add_err");

      // LDI with a second LDI start while busy at N+2
      drive_start(2, 4'b1010);
      tick();
      clear_starts();
      check("ldi_busy@1", obs(2), ev(2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
      tick();
      check("ldi_busy@2", obs(2), ev(2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
      drive_start(2, 4'b1010);
      tick();
      clear_starts();
      repeat (2) exp_q.push_back(ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(ev(2'd3, 1'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(IDLE_V);
      exp_q.push_back(IDLE_V);
      drain(2, "ldi_busy_tail");

      // Back-to-back ST then STR, ACCESS_CYCLES=1
      drive_start(1, 4'b0011);
      tick();
      clear_starts();
      check("b2b@1", obs(1), ev(2'd2, 1'b0, 1'b1, 1'b0, 1'b0));
      tick();
      check("b2b@2", obs(1), ev(2'd3, 1'b0, 1'b0, 1'b1, 1'b0));
      drive_start(1, 4'b0111);
      tick();
      clear_starts();
      exp_q.push_back(ev(2'd2, 1'b0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(ev(2'd3, 1'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(IDLE_V);
      drain(1, "b2b_tail");

      // LDI, ACCESS_CYCLES=3, reset in second READ cycle
      drive_start(3, 4'b1010);
      tick();
      clear_starts();
      repeat (3) exp_q.push_back(ev(2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
      drain(3, "ldi_rst");
      check("ldi_rst@5", obs(3), ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
      reset3 = 1'b1;
      tick();
      reset3 = 1'b0;
      exp_q.push_back(IDLE_V);
      exp_q.push_back(IDLE_V);
      drain(3, "ldi_rst_after");

      // LD after the abort completes normally with M_Control=0
      drive_start(3, 4'b0010);
      tick();
      clear_starts();
      repeat (3) exp_q.push_back(ev(2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(ev(2'd3, 1'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(IDLE_V);
      drain(3, "ld_ac3");

      // Reset wins over a simultaneous start
      reset3 = 1'b1;
      drive_start(3, 4'b0011);
      tick();
      reset3 = 1'b0;
      clear_starts();
      exp_q.push_back(IDLE_V);
      exp_q.push_back(IDLE_V);
      drain(3, "rst_prio");

      // Final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/memaccess_seq.md
Name: memaccess_seq

Overview:
- Upstream sequencer for the LC-3 memaccess stage.
- Accepts a memory-class instruction from the Execute/Controller boundary and generates the `mem_state` and `M_Control` sequence that memaccess consumes.
- Handles the direct forms (LD, LDR, ST, STR) and the two-access indirect forms (LDI, STI).
- Holds the pipeline with `stall` and flags completion with `done`.

Parameters:
ACCESS_CYCLES, 1, clock cycles each memory-access state is held (legal 1..15; 4-bit counter)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears sequencer to IDLE
start  input  1  request strobe; sampled only when sequencer is in IDLE
opcode  input  4  IR[15:12] of the requesting instruction, sampled with start
mem_state  output  2  access type to memaccess: 0=read, 1=indirect-address read, 2=write, 3=idle
M_Control  output  1  address select to memaccess: 0=use M_Addr, 1=use DMem_dout (second access of LDI/STI)
stall  output  1  high whenever sequencer is not IDLE
done  output  1  one-cycle pulse on the first IDLE cycle after the final access
err  output  1  one-cycle pulse when start is accepted with a non-memory opcode

Behaviour:
- Reset values (also after any reset, including mid-operation): state=IDLE, mem_state=3, M_Control=0, stall=0, done=0, err=0, counter=0.
- Reset has priority over start.
- All outputs are registered; mem_state and M_Control decode directly from the state register.
- Opcode classes:
  - LD=0010, LDR=0110 → READ only
  - ST=0011, STR=0111 → WRITE only
  - LDI=1010 → IND_READ then READ
  - STI=1011 → IND_READ then WRITE
  - Any other opcode → non-memory
- States:
  - IDLE: mem_state=3, M_Control=0, stall=0
  - IND_READ: mem_state=1, M_Control=0
  - READ: mem_state=0; M_Control=1 if entered from IND_READ, else 0
  - WRITE: mem_state=2; M_Control=1 if entered from IND_READ, else 0
- Transitions:
  - IDLE, start=1, memory opcode: next state is IND_READ for LDI/STI, READ for LD/LDR, WRITE for ST/STR. Counter loads ACCESS_CYCLES-1.
  - IDLE, start=1, non-memory opcode: stay IDLE; err=1 next cycle.
  - IND_READ/READ/WRITE with counter≠0: stay; decrement counter.
  - IND_READ with counter=0: go to READ (LDI) or WRITE (STI); reload counter; set indirect flag so M_Control=1.
  - READ/WRITE with counter=0: go to IDLE; done=1 in that IDLE cycle; clear indirect flag.
- start is ignored while not IDLE; opcode is don't-care then. The latched class is held internally.
- Back-to-back: start in the cycle where done=1 (state IDLE) is accepted. done and the new access state are not concurrent; stall rises the next cycle.
- Latency from the start edge to done:
  - Direct: ACCESS_CYCLES+1 cycles
  - Indirect: 2*ACCESS_CYCLES+1 cycles
- done and err are never high together. Both are low in all non-IDLE states.
- ACCESS_CYCLES outside 1..15: elaboration error (generate-time check).

Test Plan:
- Reset, then idle 5 cycles → mem_state=3, M_Control=0, stall=0, done=0, err=0 every cycle.
- ACCESS_CYCLES=1, start with opcode=0010 (LD) at cycle N:
  - N+1: mem_state=0, M_Control=0, stall=1
  - N+2: mem_state=3, done=1, stall=0
- ACCESS_CYCLES=2, start with opcode=1011 (STI) at N:
  - N+1..N+2: mem_state=1, M_Control=0
  - N+3..N+4: mem_state=2, M_Control=1
  - N+5: done=1, mem_state=3
- Start with opcode=0001 (ADD) → err=1 for one cycle, mem_state stays 3, stall=0. Then start with LDI (1010) while busy at N+2 → ignored, single sequence completes.
- Back-to-back at ACCESS_CYCLES=1: ST (0011) then STR (0111) asserted in the done cycle → mem_state sequence 2,3,2,3 with done pulses at N+2 and N+4.
- LDI with ACCESS_CYCLES=3, reset asserted in the second READ cycle → next cycle mem_state=3, M_Control=0, stall=0, done=0. A following LD completes normally with M_Control=0.
